// File: rtl/cluster_eval_pipe_if.sv
// Stream bundle for cluster_eval_pipe: input beats, output results,
// and the hit counter with its clear.
interface cluster_eval_pipe_if #(
    parameter int NUM_GROUPS = 5,
    parameter int CNT_W      = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_GROUPS*5-1:0] in_data;
    logic [1:0]              in_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_hit;
    logic [NUM_GROUPS-1:0]   out_mask;
    logic [CNT_W-1:0]        hit_count;
    logic                    clr_count;

    modport master (
        output in_valid, in_data, in_mode, out_ready, clr_count,
        input  in_ready, out_valid, out_hit, out_mask, hit_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready, clr_count,
        output in_ready, out_valid, out_hit, out_mask, hit_count
    );
endinterface

// File: rtl/cluster_eval_pipe.sv
// Two-stage cluster evaluator: S1 holds per-group predicates, S2 holds
// the reduced hit; skid-free valid/ready with a saturating hit counter.
module cluster_eval_pipe #(
    parameter int NUM_GROUPS = 5,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                rst,
    cluster_eval_pipe_if.slave bus
);
    localparam int N = NUM_GROUPS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     w_a;
    logic [N-1:0]     w_b;
    logic [N-1:0]     w_b_rot;
    logic             w_hit;
    logic             w_adv1;
    logic             w_adv2;
    logic             w_out_fire;

    logic             r_s1_valid;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [1:0]       r_mode;
    logic             r_s2_valid;
    logic             r_hit;
    logic [N-1:0]     r_mask;
    logic [CNT_W-1:0] r_cnt;

    for (genvar g = 0; g < N; g++) begin : g_pred
        logic [4:0] w_f;
        assign w_f    = bus.in_data[5*g +: 5];
        assign w_a[g] = w_f[2] ? (w_f[0] | w_f[1])
                               : ((w_f[0] ^ w_f[1]) & (w_f[3] ^ w_f[4]));
        assign w_b[g] = ~w_f[2] & ~(w_f[3] & ~w_f[4]) & (w_f[0] | w_f[1]);
    end

    // Bit g of the rotated vector is B of group g+1, wrapping to group 0.
    assign w_b_rot = {r_b[0], r_b[N-1:1]};

    always_comb begin
        w_hit = 1'b0;
        unique case (r_mode)
            2'd0: w_hit = |(r_a & w_b_rot);
            2'd1: w_hit = |r_a;
            2'd2: w_hit = ($countones(r_a) > (N / 2));
            2'd3: w_hit = &r_a;
        endcase
    end

    assign w_adv2     = ~r_s2_valid | bus.out_ready;
    assign w_adv1     = ~r_s1_valid | w_adv2;
    assign w_out_fire = r_s2_valid & bus.out_ready;

    // Payload loads only with a valid beat so idle X never reaches outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_mode     <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_a    <= w_a;
                r_b    <= w_b;
                r_mode <= bus.in_mode;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_hit      <= 1'b0;
            r_mask     <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_hit  <= w_hit;
                r_mask <= r_a;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.clr_count) begin
            r_cnt <= '0;
        end else if (w_out_fire && r_hit && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_hit   = r_hit;
    assign bus.out_mask  = r_mask;
    assign bus.hit_count = r_cnt;
endmodule
